// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: operation offer on the in_* side, registered result on the out_* side.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, ctrl, x, y, out_ready,
        input  in_ready, out_valid, out, carry, ovf, zero, illegal
    );

    modport slave (
        input  in_valid, ctrl, x, y, out_ready,
        output in_ready, out_valid, out, carry, ovf, zero, illegal
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake and 1-cycle latency for single-cycle ops.
// Define ALU_MUL_EN to add the multi-cycle shift-add unsigned multiply on opcode 1101.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = SHW + 1;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           r_state, w_state_nxt;
    logic             w_accept;
    logic             w_mul_start;
    logic             w_mul_last;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_lo;
    logic             w_mul_cy;
    logic [WIDTH+2:0] w_res;

    logic             r_vld_p1;
    logic [WIDTH-1:0] r_out_p1;
    logic             r_carry_p1;
    logic             r_ovf_p1;
    logic             r_zero_p1;
    logic             r_ill_p1;

    // Returns {illegal, ovf, carry, result} for every single-cycle opcode.
    function automatic logic [WIDTH+2:0] alu_op(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic signed [WIDTH:0] ext;
        logic [WIDTH-1:0]      r;
        logic                  c, v, ill;
        ext = '0;
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        ill = 1'b0;
        case (op)
            4'h0: begin
                ext = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
                r   = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            4'h1: begin
                ext = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
                r   = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = ~a;
            4'h5: r = a ^ b;
            4'h6: r = ~(a | b);
            4'h7: r = b << a[SHW-1:0];
            4'h8: r = b >> a[SHW-1:0];
            4'h9: r = {a[WIDTH-1], a[WIDTH-1:1]};
            4'hA: r = {a[WIDTH-2:0], a[WIDTH-1]};
            4'hB: r = {a[0], a[WIDTH-1:1]};
            4'hC: r = {{(WIDTH-1){1'b0}}, (a == b)};
            default: ill = 1'b1;
        endcase
        return {ill, v, c, r};
    endfunction

    assign bus.in_ready = (r_state == S_IDLE) && (!r_vld_p1 || bus.out_ready);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_res        = alu_op(bus.ctrl, bus.x, bus.y);

`ifdef ALU_MUL_EN
    localparam logic [CNTW-1:0] CNT_DONE = CNTW'(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNTW-1:0]    r_cnt;

    assign w_mul_start = w_accept && (bus.ctrl == 4'hD);
    assign w_mul_last  = (r_cnt == CNT_DONE);
    assign w_mul_lo    = r_acc[WIDTH-1:0];
    assign w_mul_cy    = |r_acc[2*WIDTH-1:WIDTH];

    // One shift-add step per cycle; the extra cycle after the last step publishes the product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (w_mul_start) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, bus.x};
            r_mplier <= bus.y;
            r_cnt    <= '0;
        end else if (r_state == S_MUL && !w_mul_last) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNTW'(1);
        end
    end
`else
    assign w_mul_start = 1'b0;
    assign w_mul_last  = 1'b0;
    assign w_mul_lo    = '0;
    assign w_mul_cy    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mul_done  = 1'b0;
        case (r_state)
            S_IDLE: if (w_mul_start) w_state_nxt = S_MUL;
            S_MUL: begin
                if (w_mul_last) begin
                    w_state_nxt = S_IDLE;
                    w_mul_done  = 1'b1;
                end
            end
        endcase
    end

    // p1: result register, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1   <= 1'b0;
            r_out_p1   <= '0;
            r_carry_p1 <= 1'b0;
            r_ovf_p1   <= 1'b0;
            r_zero_p1  <= 1'b0;
            r_ill_p1   <= 1'b0;
        end else if (w_accept && !w_mul_start) begin
            r_vld_p1   <= 1'b1;
            r_out_p1   <= w_res[WIDTH-1:0];
            r_carry_p1 <= w_res[WIDTH];
            r_ovf_p1   <= w_res[WIDTH+1];
            r_ill_p1   <= w_res[WIDTH+2];
            r_zero_p1  <= (w_res[WIDTH-1:0] == '0);
        end else if (w_mul_done) begin
            r_vld_p1   <= 1'b1;
            r_out_p1   <= w_mul_lo;
            r_carry_p1 <= w_mul_cy;
            r_ovf_p1   <= 1'b0;
            r_ill_p1   <= 1'b0;
            r_zero_p1  <= (w_mul_lo == '0);
        end else if (r_vld_p1 && bus.out_ready) begin
            r_vld_p1   <= 1'b0;
        end
    end

    assign bus.out_valid = r_vld_p1;
    assign bus.out       = r_out_p1;
    assign bus.carry     = r_carry_p1;
    assign bus.ovf       = r_ovf_p1;
    assign bus.zero      = r_zero_p1;
    assign bus.illegal   = r_ill_p1;
endmodule
